// File: rtl/regfile_write_demux.sv
// regfile_write_demux: queues register-file write-back requests and drains them one per cycle onto a one-hot enable bus
//   clk, reset_n          clock; asynchronous active-low reset
//   in_valid/in_ready     write request handshake carrying in_addr/in_data
//   rf_hold               register file busy; blocks draining
//   wr_en/wr_addr/wr_data registered write issued to the register file
//   pending               per-register "write in flight" bits
//   q_addr/q_hit/q_data   combinational bypass lookup of the youngest in-flight value
module regfile_write_demux #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int ZERO_REG = 31
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ADDR_W-1:0]    in_addr,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 rf_hold,
   output logic [2**ADDR_W-1:0] wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [DATA_W-1:0]    wr_data,
   output logic [2**ADDR_W-1:0] pending,
   input  logic [ADDR_W-1:0]    q_addr,
   output logic                 q_hit,
   output logic [DATA_W-1:0]    q_data
);
   localparam int N = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

   // decode that never asserts the hard-wired zero register
   function automatic logic [N-1:0] dec(input logic [ADDR_W-1:0] a);
      return (a == ZA) ? '0 : {{(N-1){1'b0}}, 1'b1} << a;
   endfunction

   logic [1:0]        count;
   logic [ADDR_W-1:0] e_addr [2];
   logic [DATA_W-1:0] e_data [2];
   logic              push, pop;

   // entry 0 is always the head; entry 1 is valid only when count == 2
   assign in_ready = (count != 2'd2);
   assign push     = in_valid && in_ready;
   assign pop      = (count != 2'd0) && !rf_hold;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count     <= 2'd0;
         wr_en     <= '0;
         wr_addr   <= '0;
         wr_data   <= '0;
         e_addr[0] <= '0;
         e_addr[1] <= '0;
         e_data[0] <= '0;
         e_data[1] <= '0;
      end else begin
         count <= count + 2'(push) - 2'(pop);
         wr_en <= pop ? dec(e_addr[0]) : '0;
         if (pop) begin
            wr_addr   <= e_addr[0];
            wr_data   <= e_data[0];
            // push into a single-entry queue while it drains lands directly at the head
            e_addr[0] <= (push && count == 2'd1) ? in_addr : e_addr[1];
            e_data[0] <= (push && count == 2'd1) ? in_data : e_data[1];
         end else if (push) begin
            e_addr[count[0]] <= in_addr;
            e_data[count[0]] <= in_data;
         end
      end
   end

   assign pending = (count != 2'd0 ? dec(e_addr[0]) : '0)
                  | (count == 2'd2 ? dec(e_addr[1]) : '0)
                  | wr_en;

   assign q_hit  = pending[q_addr];
   // youngest first: queue tail, queue head, then the output stage
   assign q_data = !q_hit ? '0
                 : (count == 2'd2 && e_addr[1] == q_addr) ? e_data[1]
                 : (count != 2'd0 && e_addr[0] == q_addr) ? e_data[0]
                 : wr_data;
endmodule

// File: tb/tb_regfile_write_demux.sv
// tb_regfile_write_demux: directed self-checking bench for regfile_write_demux
module tb_regfile_write_demux;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic        rf_hold;
   logic [31:0] wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] pending;
   logic [4:0]  q_addr;
   logic        q_hit;
   logic [31:0] q_data;
   int          n_cmp = 0;
   int          n_err = 0;

   regfile_write_demux dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .rf_hold(rf_hold), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending), .q_addr(q_addr),
      .q_hit(q_hit), .q_data(q_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
      in_valid = v;
      in_addr  = a;
      in_data  = d;
   endtask

   initial begin
      reset_n = 1'b0;
      rf_hold = 1'b0;
      q_addr  = 5'd0;
      drive(1'b0, 5'd0, 32'd0);
      #2;
      check("rst_ready", in_ready, 1);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_pending", pending, 0);
      check("rst_q_hit", q_hit, 0);
      @(negedge clk) reset_n = 1'b1;

      // single write to r5: one-cycle enable pulse one edge after acceptance
      @(negedge clk) drive(1'b1, 5'd5, 32'hDEADBEEF);
      @(negedge clk);
      check("t1_wr_en_e1", wr_en, 0);
      check("t1_pend_e1", pending, 32'h20);
      drive(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      check("t1_wr_en_e2", wr_en, 32'h20);
      check("t1_wr_addr", wr_addr, 5);
      check("t1_wr_data", wr_data, 32'hDEADBEEF);
      check("t1_pend_e2", pending, 32'h20);
      @(negedge clk);
      check("t1_wr_en_e3", wr_en, 0);
      check("t1_pend_e3", pending, 0);
      check("t1_wr_addr_hold", wr_addr, 5);

      // write to the zero register occupies a slot but never enables
      @(negedge clk) drive(1'b1, 5'd31, 32'h1234);
      @(negedge clk);
      check("t2_wr_en_e1", wr_en, 0);
      check("t2_pend_e1", pending, 0);
      check("t2_ready", in_ready, 1);
      drive(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      check("t2_wr_en_e2", wr_en, 0);
      check("t2_wr_addr", wr_addr, 31);
      check("t2_wr_data", wr_data, 32'h1234);
      check("t2_pend_e2", pending, 0);

      // fill under rf_hold, then drain in order
      @(negedge clk) begin rf_hold = 1'b1; drive(1'b1, 5'd3, 32'h3); end
      @(negedge clk) drive(1'b1, 5'd7, 32'h7);
      @(negedge clk);
      check("t3_full_ready", in_ready, 0);
      drive(1'b1, 5'd9, 32'h9);
      @(negedge clk);
      check("t3_held_ready", in_ready, 0);
      check("t3_pend", pending, 32'h88);
      check("t3_hold_wr_en", wr_en, 0);
      rf_hold = 1'b0;
      @(negedge clk);
      check("t3_wr_en_3", wr_en, 32'h8);
      check("t3_ready_up", in_ready, 1);
      @(negedge clk);
      check("t3_wr_en_7", wr_en, 32'h80);
      check("t3_wr_data_7", wr_data, 32'h7);
      drive(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      check("t3_wr_en_9", wr_en, 32'h200);
      check("t3_wr_data_9", wr_data, 32'h9);
      @(negedge clk);
      check("t3_wr_en_done", wr_en, 0);

      // write-after-write bypass returns the youngest value
      @(negedge clk) begin rf_hold = 1'b1; drive(1'b1, 5'd4, 32'h11); end
      @(negedge clk) drive(1'b1, 5'd4, 32'h22);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0);
      q_addr = 5'd4;
      #1;
      check("t4_hit", q_hit, 1);
      check("t4_data", q_data, 32'h22);
      q_addr = 5'd5;
      #1;
      check("t4_miss_hit", q_hit, 0);
      check("t4_miss_data", q_data, 0);
      q_addr  = 5'd4;
      rf_hold = 1'b0;
      @(negedge clk);
      check("t4_wr_data_1", wr_data, 32'h11);
      check("t4_mid_data", q_data, 32'h22);
      @(negedge clk);
      check("t4_wr_data_2", wr_data, 32'h22);
      check("t4_out_hit", q_hit, 1);
      check("t4_out_data", q_data, 32'h22);
      @(negedge clk);
      check("t4_end_hit", q_hit, 0);
      check("t4_end_data", q_data, 0);

      // continuous stream, one write per cycle
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i < 8) check($sformatf("t5_ready_%0d", i), in_ready, 1);
         if (i >= 2) check($sformatf("t5_wr_en_%0d", i - 2), wr_en, 64'd1 << (i - 2));
         if (i >= 2) check($sformatf("t5_wr_data_%0d", i - 2), wr_data, (i - 2) * 16);
         if (i < 8) drive(1'b1, 5'(i), 32'(i * 16));
         else drive(1'b0, 5'd0, 32'd0);
      end
      @(negedge clk);
      check("t5_done", wr_en, 0);

      // asynchronous reset with writes in flight
      @(negedge clk) begin rf_hold = 1'b1; drive(1'b1, 5'd8, 32'h88); end
      @(negedge clk) drive(1'b1, 5'd10, 32'hAA);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0);
      rf_hold = 1'b0;
      @(negedge clk);
      check("t6_wr_en_pre", wr_en, 32'h100);
      check("t6_pend_pre", pending, 32'h500);
      #1 reset_n = 1'b0;
      #1;
      check("t6_wr_en_rst", wr_en, 0);
      check("t6_pend_rst", pending, 0);
      check("t6_ready_rst", in_ready, 1);
      q_addr = 5'd10;
      #1;
      check("t6_q_hit_rst", q_hit, 0);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      check("t6_wr_en_post1", wr_en, 0);
      check("t6_pend_post1", pending, 0);
      @(negedge clk);
      check("t6_wr_en_post2", wr_en, 0);
      check("t6_ready_post", in_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
